alu_op_encoder: RTL and testbench

Issue-side counterpart of the ALU opcode decoder. It accepts ALU commands expressed as 4-bit ALU control codes with operands and encodes each into the 3-bit opcode the decoder consumes. Encoded commands are buffered in a small FIFO and presented downstream over a valid/ready handshake. It sits between the command source (sequencer or testbench master) and the decode/execute stage, drops NOP codes, and flags illegal codes.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_op_encoder.sv | 85 ++++++++
 tb/tb_alu_op_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control/opcode definitions and encode helpers for the issue side.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned OPC_W  = 3;

  typedef enum logic [CTRL_W-1:0] {
    CTRL_ADD = 4'b0000,
    CTRL_SUB = 4'b0001,
    CTRL_AND = 4'b0010,
    CTRL_OR  = 4'b0011,
    CTRL_XOR = 4'b0100,
    CTRL_SLT = 4'b0101,
    CTRL_NOP = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101
  } alu_opcode_e;

  // NOP is consumed silently by the encoder.
  function automatic logic is_nop(input logic [CTRL_W-1:0] ctrl);
    return ctrl == CTRL_NOP;
  endfunction

  // Only the six real ALU operations are forwarded to the decoder.
  function automatic logic is_legal(input logic [CTRL_W-1:0] ctrl);
    return ctrl <= CTRL_W'(CTRL_SLT);
  endfunction

  // Control code to decoder opcode; non-legal codes never reach the FIFO.
  function automatic alu_opcode_e encode(input logic [CTRL_W-1:0] ctrl);
    case (ctrl)
      CTRL_ADD: return OP_ADD;
      CTRL_SUB: return OP_SUB;
      CTRL_AND: return OP_AND;
      CTRL_OR:  return OP_OR;
      CTRL_XOR: return OP_XOR;
      CTRL_SLT: return OP_SLT;
      default:  return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding encoded commands; registered read, no fall-through.
module alu_cmd_fifo #(
  parameter int unsigned W     = 67,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents are don't-care until covered by level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_encoder.sv
// Encodes ALU control codes into decoder opcodes, buffers them, and tracks stats.
module alu_op_encoder
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_ctrl,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_opcode,
  output logic [DATA_W-1:0]      out_a,
  output logic [DATA_W-1:0]      out_b,
  output logic [$clog2(DEPTH):0] level,
  output logic                   illegal_pulse,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic [CNT_W-1:0]       illegal_cnt
);

  localparam int unsigned ENTRY_W = OPC_W + 2 * DATA_W;

  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic               illegal;

  // Handshakes derive from registered occupancy only; both are held low in reset.
  assign in_ready  = rst_n && !fifo_full;
  assign out_valid = rst_n && !fifo_empty;

  assign accept   = in_valid && in_ready;
  assign push     = accept && is_legal(in_ctrl);
  assign illegal  = accept && !is_legal(in_ctrl) && !is_nop(in_ctrl);
  assign pop      = out_valid && out_ready;
  assign fifo_din = {OPC_W'(encode(in_ctrl)), in_a, in_b};

  // Head entry is exposed only while valid so an empty buffer presents zeros.
  assign out_opcode = out_valid ? fifo_dout[ENTRY_W-1 -: OPC_W]        : '0;
  assign out_a      = out_valid ? fifo_dout[2*DATA_W-1 -: DATA_W]      : '0;
  assign out_b      = out_valid ? fifo_dout[DATA_W-1:0]                : '0;

  alu_cmd_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One-cycle illegal flag plus saturating issue/illegal statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_pulse <= 1'b0;
      issued_cnt    <= '0;
      illegal_cnt   <= '0;
    end else begin
      illegal_pulse <= illegal;
      if (pop && (issued_cnt != '1)) begin
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      if (illegal && (illegal_cnt != '1)) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_encoder.sv
// Directed table-driven bench for alu_op_encoder with reset corner sequences.
module tb_alu_op_encoder;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_ctrl;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_opcode;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [2:0]        level;
  logic              illegal_pulse;
  logic [CNT_W-1:0]  issued_cnt;
  logic [CNT_W-1:0]  illegal_cnt;

  always #5 clk = ~clk;

  alu_op_encoder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl       (in_ctrl),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_a         (out_a),
    .out_b         (out_b),
    .level         (level),
    .illegal_pulse (illegal_pulse),
    .issued_cnt    (issued_cnt),
    .illegal_cnt   (illegal_cnt)
  );

  typedef struct {
    logic        iv;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ordy;
    logic [2:0]  e_level;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_irdy;
    logic        e_pulse;
    logic [15:0] e_iss;
    logic [15:0] e_ill;
  } vec_t;

  vec_t vecs[$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [3:0] ctrl, input logic [31:0] a,
                              input logic [31:0] b, input logic ordy, input logic [2:0] lvl,
                              input logic vld, input logic [2:0] op, input logic [31:0] ea,
                              input logic [31:0] eb, input logic irdy, input logic pulse,
                              input logic [15:0] iss, input logic [15:0] ill);
    vec_t v;
    v.iv = iv; v.ctrl = ctrl; v.a = a; v.b = b; v.ordy = ordy;
    v.e_level = lvl; v.e_valid = vld; v.e_op = op; v.e_a = ea; v.e_b = eb;
    v.e_irdy = irdy; v.e_pulse = pulse; v.e_iss = iss; v.e_ill = ill;
    return v;
  endfunction

  task automatic check_state(input string p, input logic [2:0] lvl, input logic vld,
                             input logic [2:0] op, input logic [31:0] ea, input logic [31:0] eb,
                             input logic irdy, input logic pulse, input logic [15:0] iss,
                             input logic [15:0] ill);
    chk({p, " level"},         64'(level),         64'(lvl));
    chk({p, " out_valid"},     64'(out_valid),     64'(vld));
    chk({p, " out_opcode"},    64'(out_opcode),    64'(op));
    chk({p, " out_a"},         64'(out_a),         64'(ea));
    chk({p, " out_b"},         64'(out_b),         64'(eb));
    chk({p, " in_ready"},      64'(in_ready),      64'(irdy));
    chk({p, " illegal_pulse"}, 64'(illegal_pulse), 64'(pulse));
    chk({p, " issued_cnt"},    64'(issued_cnt),    64'(iss));
    chk({p, " illegal_cnt"},   64'(illegal_cnt),   64'(ill));
  endtask

  task automatic drive(input logic iv, input logic [3:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy);
    in_valid = iv; in_ctrl = ctrl; in_a = a; in_b = b; out_ready = ordy;
  endtask

  initial begin
    //          iv ctrl   a   b   rdy  lvl vld op  ea  eb  irdy pls iss ill
    // Reset then ADD, then pop
    vecs.push_back(mk(1, 4'h0,  5,  3, 0,  1, 1, 0,  5,  3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 4'h0,  0,  0, 1,  0, 0, 0,  0,  0, 1, 0, 1, 0));
    // Streaming with out_ready=1
    vecs.push_back(mk(1, 4'h1, 10,  1, 1,  1, 1, 1, 10,  1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 4'h2, 11,  2, 1,  1, 1, 2, 11,  2, 1, 0, 2, 0));
    vecs.push_back(mk(1, 4'h3, 12,  3, 1,  1, 1, 3, 12,  3, 1, 0, 3, 0));
    vecs.push_back(mk(1, 4'h4, 13,  4, 1,  1, 1, 4, 13,  4, 1, 0, 4, 0));
    vecs.push_back(mk(1, 4'h5, 14,  5, 1,  1, 1, 5, 14,  5, 1, 0, 5, 0));
    vecs.push_back(mk(0, 4'h0,  0,  0, 1,  0, 0, 0,  0,  0, 1, 0, 6, 0));
    // NOP and illegal codes, including back-to-back illegal
    vecs.push_back(mk(1, 4'hF, 99, 99, 0,  0, 0, 0,  0,  0, 1, 0, 6, 0));
    vecs.push_back(mk(1, 4'hA, 99, 99, 0,  0, 0, 0,  0,  0, 1, 1, 6, 1));
    vecs.push_back(mk(0, 4'h0,  0,  0, 0,  0, 0, 0,  0,  0, 1, 0, 6, 1));
    vecs.push_back(mk(1, 4'h6, 98, 98, 0,  0, 0, 0,  0,  0, 1, 1, 6, 2));
    vecs.push_back(mk(1, 4'hE, 97, 97, 0,  0, 0, 0,  0,  0, 1, 1, 6, 3));
    vecs.push_back(mk(0, 4'h0,  0,  0, 0,  0, 0, 0,  0,  0, 1, 0, 6, 3));
    // Fill to full with out_ready=0; fifth is held
    vecs.push_back(mk(1, 4'h0, 20, 120, 0, 1, 1, 0, 20, 120, 1, 0, 6, 3));
    vecs.push_back(mk(1, 4'h1, 21, 121, 0, 2, 1, 0, 20, 120, 1, 0, 6, 3));
    vecs.push_back(mk(1, 4'h2, 22, 122, 0, 3, 1, 0, 20, 120, 1, 0, 6, 3));
    vecs.push_back(mk(1, 4'h3, 23, 123, 0, 4, 1, 0, 20, 120, 0, 0, 6, 3));
    vecs.push_back(mk(1, 4'h4, 24, 124, 0, 4, 1, 0, 20, 120, 0, 0, 6, 3));
    // Full with push+pop: push refused, level drops to 3
    vecs.push_back(mk(1, 4'h4, 24, 124, 1, 3, 1, 1, 21, 121, 1, 0, 7, 3));
    // Held fifth accepted now
    vecs.push_back(mk(1, 4'h4, 24, 124, 0, 4, 1, 1, 21, 121, 0, 0, 7, 3));
    vecs.push_back(mk(0, 4'h0,  0,   0, 1, 3, 1, 2, 22, 122, 1, 0, 8, 3));
    vecs.push_back(mk(0, 4'h0,  0,   0, 1, 2, 1, 3, 23, 123, 1, 0, 9, 3));
    // Level 2 with push+pop: level stays 2, order kept
    vecs.push_back(mk(1, 4'h5, 25, 125, 1, 2, 1, 4, 24, 124, 1, 0, 10, 3));
    vecs.push_back(mk(0, 4'h0,  0,   0, 1, 1, 1, 5, 25, 125, 1, 0, 11, 3));
    // Build level 3 ahead of the mid-stream reset
    vecs.push_back(mk(1, 4'h0, 30, 130, 0, 2, 1, 5, 25, 125, 1, 0, 11, 3));
    vecs.push_back(mk(1, 4'h1, 31, 131, 0, 3, 1, 5, 25, 125, 1, 0, 11, 3));

    // Power-on reset, with a command offered that must be ignored
    rst_n = 1'b0;
    drive(1, 4'h0, 77, 77, 1);
    #1;
    chk("reset in_ready low", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    check_state("por", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 4'h0, 0, 0, 0);

    // Table-driven main sequence
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].ordy);
      @(posedge clk); #1;
      check_state($sformatf("v%0d", i), vecs[i].e_level, vecs[i].e_valid, vecs[i].e_op,
                  vecs[i].e_a, vecs[i].e_b, vecs[i].e_irdy, vecs[i].e_pulse,
                  vecs[i].e_iss, vecs[i].e_ill);
    end

    // Mid-stream reset with level=3 and counters nonzero; no partial pop
    rst_n = 1'b0;
    drive(1, 4'h2, 50, 150, 1);
    #1;
    chk("midrst in_ready low", 64'(in_ready), 64'(0));
    chk("midrst out_valid low", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check_state("midrst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // First command after reset emerges next cycle, then pops
    drive(1, 4'h2, 40, 41, 0);
    @(posedge clk); #1;
    check_state("post_push", 1, 1, 2, 40, 41, 1, 0, 0, 0);
    drive(0, 4'h0, 0, 0, 1);
    @(posedge clk); #1;
    check_state("post_pop", 0, 0, 0, 0, 0, 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
